// File: rtl/decode_pkg.sv
// Shared constants and the decoded-bundle type for the RV32I decode stage.
// Field encodings match the id_* outputs of decode_stage.
package decode_pkg;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [2:0] IMM_I  = 3'b000;
  localparam logic [2:0] IMM_S  = 3'b001;
  localparam logic [2:0] IMM_B  = 3'b010;
  localparam logic [2:0] IMM_U  = 3'b011;
  localparam logic [2:0] IMM_J  = 3'b100;
  localparam logic [2:0] IMM_C  = 3'b101;
  localparam logic [2:0] IMM_SH = 3'b110;

  localparam logic [1:0] SEL_REG  = 2'b00;
  localparam logic [1:0] SEL_IMM  = 2'b01;
  localparam logic [1:0] SEL_PC   = 2'b10;
  localparam logic [1:0] SEL_ZERO = 2'b11;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;

  localparam int CTRL_LUI      = 0;
  localparam int CTRL_AUIPC    = 1;
  localparam int CTRL_JAL      = 2;
  localparam int CTRL_JALR     = 3;
  localparam int CTRL_BRANCH   = 4;
  localparam int CTRL_MEM      = 5;
  localparam int CTRL_WE_MEM   = 6;
  localparam int CTRL_MISC_MEM = 7;
  localparam int CTRL_SYSTEM   = 8;
  localparam int CTRL_W        = 9;

  localparam logic [6:0] F7_ZERO   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef struct packed {
    logic [2:0]        funct3;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic [11:0]       csr_addr;
    logic [2:0]        imm_op;
    logic [1:0]        sel_a;
    logic [1:0]        sel_b;
    logic [3:0]        alu_op;
    logic [CTRL_W-1:0] ctrl;
    logic              muldiv;
    logic              illegal;
  } decode_bundle_t;

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side and execute-side signals of decode_stage. Transfer on either side
// happens when valid && ready at a rising edge; a valid bundle stays stable until taken.
interface decode_stage_if #(
  parameter int PC_W          = 32,
  parameter int ALU_OP_W      = 4,
  parameter int ILLEGAL_CNT_W = 16
);
  logic                     if_valid_i;
  logic                     if_ready_o;
  logic [31:0]              if_instr_i;
  logic [PC_W-1:0]          if_pc_i;
  logic                     id_valid_o;
  logic                     id_ready_i;
  logic [PC_W-1:0]          id_pc_o;
  logic [2:0]               id_funct3_o;
  logic [4:0]               id_rs1_o;
  logic [4:0]               id_rs2_o;
  logic [4:0]               id_rd_o;
  logic [11:0]              id_csr_addr_o;
  logic [2:0]               id_imm_op_o;
  logic [1:0]               id_sel_a_o;
  logic [1:0]               id_sel_b_o;
  logic [ALU_OP_W-1:0]      id_alu_op_o;
  logic [8:0]               id_ctrl_o;
  logic                     id_muldiv_o;
  logic                     id_illegal_o;
  logic [ILLEGAL_CNT_W-1:0] illegal_cnt_o;

  // master: the pipeline around the stage (fetch + execute)
  modport master (
    output if_valid_i, if_instr_i, if_pc_i, id_ready_i,
    input  if_ready_o, id_valid_o, id_pc_o, id_funct3_o, id_rs1_o, id_rs2_o, id_rd_o,
           id_csr_addr_o, id_imm_op_o, id_sel_a_o, id_sel_b_o, id_alu_op_o, id_ctrl_o,
           id_muldiv_o, id_illegal_o, illegal_cnt_o
  );

  modport slave (
    input  if_valid_i, if_instr_i, if_pc_i, id_ready_i,
    output if_ready_o, id_valid_o, id_pc_o, id_funct3_o, id_rs1_o, id_rs2_o, id_rd_o,
           id_csr_addr_o, id_imm_op_o, id_sel_a_o, id_sel_b_o, id_alu_op_o, id_ctrl_o,
           id_muldiv_o, id_illegal_o, illegal_cnt_o
  );
endinterface

// File: rtl/decode_comb.sv
// Pure combinational RV32I decoder: instruction word -> decoded bundle with legality.
// RV32M register-register ops are accepted only when DECODE_MEXT_EN is defined.
module decode_comb
  import decode_pkg::*;
(
  input  logic [31:0]    instr,
  output decode_bundle_t bundle
);

  logic [6:0]        opcode;
  logic [2:0]        f3;
  logic [6:0]        f7;
  logic              is_shift;
  logic              illegal;
  logic              op_ok;
  logic [CTRL_W-1:0] ctrl;
  logic [2:0]        imm_op;
  logic [1:0]        sel_a;
  logic [1:0]        sel_b;
  logic [3:0]        alu_op;
  logic              muldiv;

  assign opcode   = instr[6:0];
  assign f3       = instr[14:12];
  assign f7       = instr[31:25];
  assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);

  always_comb begin
    ctrl    = '0;
    imm_op  = IMM_I;
    sel_a   = SEL_REG;
    sel_b   = SEL_REG;
    alu_op  = ALU_ADD;
    muldiv  = 1'b0;
    illegal = 1'b0;
    op_ok   = 1'b0;
    unique case (opcode)
      OPC_LUI: begin
        ctrl[CTRL_LUI] = 1'b1; sel_a = SEL_IMM; sel_b = SEL_ZERO; imm_op = IMM_U;
      end
      OPC_AUIPC: begin
        ctrl[CTRL_AUIPC] = 1'b1; sel_a = SEL_PC; sel_b = SEL_IMM; imm_op = IMM_U;
      end
      OPC_JAL: begin
        ctrl[CTRL_JAL] = 1'b1; sel_a = SEL_PC; sel_b = SEL_IMM; imm_op = IMM_J;
      end
      OPC_JALR: begin
        ctrl[CTRL_JALR] = 1'b1; sel_b = SEL_IMM;
        illegal = (f3 != 3'b000);
      end
      OPC_BRANCH: begin
        ctrl[CTRL_BRANCH] = 1'b1; imm_op = IMM_B;
        illegal = (f3 == 3'b010) || (f3 == 3'b011);
      end
      OPC_LOAD: begin
        ctrl[CTRL_MEM] = 1'b1; sel_b = SEL_IMM;
        illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      OPC_STORE: begin
        ctrl[CTRL_MEM] = 1'b1; ctrl[CTRL_WE_MEM] = 1'b1; sel_b = SEL_IMM; imm_op = IMM_S;
        illegal = (f3 >= 3'b011);
      end
      OPC_OP_IMM: begin
        sel_b = SEL_IMM;
        if (is_shift) begin
          imm_op  = IMM_SH;
          alu_op  = {instr[30], f3};
          illegal = !((f7 == F7_ZERO) || (f7 == F7_ALT && f3 == 3'b101));
        end else begin
          alu_op = {1'b0, f3};
        end
      end
      OPC_OP: begin
        alu_op = {instr[30], f3};
        op_ok  = (f7 == F7_ZERO) || (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101));
`ifdef DECODE_MEXT_EN
        if (f7 == F7_MULDIV) begin
          op_ok  = 1'b1;
          muldiv = 1'b1;
          alu_op = {1'b0, f3};
        end
`endif
        illegal = !op_ok;
      end
      OPC_MISC_MEM: ctrl[CTRL_MISC_MEM] = 1'b1;
      OPC_SYSTEM: begin
        ctrl[CTRL_SYSTEM] = 1'b1; imm_op = IMM_C;
        sel_a = f3[2] ? SEL_IMM : SEL_REG;
      end
      default: illegal = 1'b1;
    endcase
    if (instr[1:0] != 2'b11) illegal = 1'b1;
    // Illegal bundles still flow downstream but must not trigger any side effect.
    if (illegal) begin
      ctrl   = '0;
      imm_op = '0;
      sel_a  = '0;
      sel_b  = '0;
      alu_op = '0;
      muldiv = 1'b0;
    end
  end

  always_comb begin
    bundle          = '0;
    bundle.funct3   = f3;
    bundle.rs1      = instr[19:15];
    bundle.rs2      = instr[24:20];
    bundle.rd       = instr[11:7];
    bundle.csr_addr = instr[31:20];
    bundle.imm_op   = imm_op;
    bundle.sel_a    = sel_a;
    bundle.sel_b    = sel_b;
    bundle.alu_op   = alu_op;
    bundle.ctrl     = ctrl;
    bundle.muldiv   = muldiv;
    bundle.illegal  = illegal;
  end

endmodule

// File: rtl/decode_stage.sv
// Registered RV32I decode stage: output register plus one skid entry, flush, and a
// saturating illegal-instruction counter. Optional RV32M decode via DECODE_MEXT_EN.
module decode_stage
  import decode_pkg::*;
#(
  parameter int PC_W          = 32,
  parameter int ALU_OP_W      = 4,
  parameter int ILLEGAL_CNT_W = 16
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           flush_i,
  decode_stage_if.slave  bus
);

  decode_bundle_t           dec;
  decode_bundle_t           out_q;
  decode_bundle_t           skid_q;
  logic [PC_W-1:0]          out_pc_q;
  logic [PC_W-1:0]          skid_pc_q;
  logic                     out_valid_q;
  logic                     skid_valid_q;
  logic [ILLEGAL_CNT_W-1:0] cnt_q;
  logic                     accept;
  logic                     out_fire;
  logic                     out_free;

  decode_comb u_comb (
    .instr  (bus.if_instr_i),
    .bundle (dec)
  );

  // Ready depends only on the registered skid flag, never on id_ready_i.
  assign bus.if_ready_o = !skid_valid_q && !rst_i;
  assign accept         = bus.if_valid_i && bus.if_ready_o && !flush_i;
  assign out_fire       = out_valid_q && bus.id_ready_i;
  assign out_free       = !out_valid_q || bus.id_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      out_q        <= '0;
      skid_q       <= '0;
      out_pc_q     <= '0;
      skid_pc_q    <= '0;
    end else if (flush_i) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (out_free) begin
      // Skid can only be full while if_ready_o is low, so accept and skid never collide.
      if (skid_valid_q) begin
        out_q        <= skid_q;
        out_pc_q     <= skid_pc_q;
        out_valid_q  <= 1'b1;
        skid_valid_q <= 1'b0;
      end else if (accept) begin
        out_q       <= dec;
        out_pc_q    <= bus.if_pc_i;
        out_valid_q <= 1'b1;
      end else begin
        out_valid_q <= 1'b0;
      end
    end else if (accept) begin
      skid_q       <= dec;
      skid_pc_q    <= bus.if_pc_i;
      skid_valid_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (out_fire && out_q.illegal && (cnt_q != {ILLEGAL_CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.id_valid_o    = out_valid_q;
  assign bus.id_pc_o       = out_pc_q;
  assign bus.id_funct3_o   = out_q.funct3;
  assign bus.id_rs1_o      = out_q.rs1;
  assign bus.id_rs2_o      = out_q.rs2;
  assign bus.id_rd_o       = out_q.rd;
  assign bus.id_csr_addr_o = out_q.csr_addr;
  assign bus.id_imm_op_o   = out_q.imm_op;
  assign bus.id_sel_a_o    = out_q.sel_a;
  assign bus.id_sel_b_o    = out_q.sel_b;
  assign bus.id_alu_op_o   = ALU_OP_W'(out_q.alu_op);
  assign bus.id_ctrl_o     = out_q.ctrl;
  assign bus.id_illegal_o  = out_q.illegal;
  assign bus.illegal_cnt_o = cnt_q;
`ifdef DECODE_MEXT_EN
  assign bus.id_muldiv_o   = out_q.muldiv;
`else
  assign bus.id_muldiv_o   = 1'b0;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode vectors, skid/backpressure ordering,
// flush, and illegal-counter saturation on a second narrow-counter instance.
module tb_decode_stage;

  logic clk;
  logic rst;
  logic flush;
  int   n_checks;
  int   n_errors;
  int   exp_cnt;

  decode_stage_if #(.PC_W(32), .ALU_OP_W(4), .ILLEGAL_CNT_W(16)) bus ();
  decode_stage_if #(.PC_W(32), .ALU_OP_W(4), .ILLEGAL_CNT_W(2))  bus2 ();

  decode_stage #(.PC_W(32), .ALU_OP_W(4), .ILLEGAL_CNT_W(16)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .flush_i (flush),
    .bus     (bus)
  );

  decode_stage #(.PC_W(32), .ALU_OP_W(4), .ILLEGAL_CNT_W(2)) dut_sat (
    .clk_i   (clk),
    .rst_i   (rst),
    .flush_i (1'b0),
    .bus     (bus2)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic rdy);
    bus.if_valid_i = v;
    bus.if_instr_i = ins;
    bus.if_pc_i    = pc;
    bus.id_ready_i = rdy;
  endtask

  task automatic check_dec(input string tag, input logic [2:0] imm, input logic [1:0] sa,
                           input logic [1:0] sb, input logic [3:0] alu,
                           input logic [8:0] ctrl, input logic ill);
    check({tag, ".valid"},   64'(bus.id_valid_o),   64'd1);
    check({tag, ".imm"},     64'(bus.id_imm_op_o),  64'(imm));
    check({tag, ".sel_a"},   64'(bus.id_sel_a_o),   64'(sa));
    check({tag, ".sel_b"},   64'(bus.id_sel_b_o),   64'(sb));
    check({tag, ".alu"},     64'(bus.id_alu_op_o),  64'(alu));
    check({tag, ".ctrl"},    64'(bus.id_ctrl_o),    64'(ctrl));
    check({tag, ".illegal"}, 64'(bus.id_illegal_o), 64'(ill));
  endtask

  // Push one instruction with execute ready, check it, then let it hand off.
  task automatic single(input string tag, input logic [31:0] ins, input logic [2:0] imm,
                        input logic [1:0] sa, input logic [1:0] sb, input logic [3:0] alu,
                        input logic [8:0] ctrl, input logic ill);
    drive(1'b1, ins, 32'h0000_0400, 1'b1);
    tick();
    check_dec(tag, imm, sa, sb, alu, ctrl, ill);
    check({tag, ".pc"}, 64'(bus.id_pc_o), 64'h400);
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    tick();
    if (ill) exp_cnt++;
    check({tag, ".cnt"}, 64'(bus.illegal_cnt_o), 64'(exp_cnt));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    exp_cnt  = 0;
    rst      = 1'b1;
    flush    = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    bus2.if_valid_i = 1'b0;
    bus2.if_instr_i = 32'h0;
    bus2.if_pc_i    = 32'h0;
    bus2.id_ready_i = 1'b1;
    tick();
    tick();
    check("rst.if_ready", 64'(bus.if_ready_o),    64'd0);
    check("rst.id_valid", 64'(bus.id_valid_o),    64'd0);
    check("rst.pc",       64'(bus.id_pc_o),       64'd0);
    check("rst.ctrl",     64'(bus.id_ctrl_o),     64'd0);
    check("rst.rd",       64'(bus.id_rd_o),       64'd0);
    check("rst.cnt",      64'(bus.illegal_cnt_o), 64'd0);
    rst = 1'b0;
    #1;
    check("post_rst.if_ready", 64'(bus.if_ready_o), 64'd1);

    // ADDI x1,x0,5
    drive(1'b1, 32'h0050_0093, 32'h0000_0100, 1'b1);
    tick();
    check_dec("addi", 3'b000, 2'b00, 2'b01, 4'b0000, 9'h000, 1'b0);
    check("addi.rd",  64'(bus.id_rd_o),  64'd1);
    check("addi.rs2", 64'(bus.id_rs2_o), 64'd5);
    check("addi.csr", 64'(bus.id_csr_addr_o), 64'h005);
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    tick();
    check("addi.drained", 64'(bus.id_valid_o), 64'd0);

    // Backpressure: A to output, B to skid, C held upstream.
    drive(1'b1, 32'h0010_0113, 32'h0000_0200, 1'b0);
    tick();
    drive(1'b1, 32'h0020_0193, 32'h0000_0204, 1'b0);
    tick();
    check("bp.if_ready_full", 64'(bus.if_ready_o), 64'd0);
    drive(1'b1, 32'h0030_0213, 32'h0000_0208, 1'b0);
    tick();
    check("bp.hold_rd",    64'(bus.id_rd_o),    64'd2);
    check("bp.hold_pc",    64'(bus.id_pc_o),    64'h200);
    check("bp.hold_ready", 64'(bus.if_ready_o), 64'd0);
    bus.id_ready_i = 1'b1;
    tick();
    check("bp.b_rd",  64'(bus.id_rd_o),    64'd3);
    check("bp.b_pc",  64'(bus.id_pc_o),    64'h204);
    check("bp.b_rdy", 64'(bus.if_ready_o), 64'd1);
    tick();
    check("bp.c_rd",    64'(bus.id_rd_o),    64'd4);
    check("bp.c_pc",    64'(bus.id_pc_o),    64'h208);
    check("bp.c_valid", 64'(bus.id_valid_o), 64'd1);
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    tick();
    check("bp.empty", 64'(bus.id_valid_o), 64'd0);

    single("srai",   32'h4010_D093, 3'b110, 2'b00, 2'b01, 4'b1101, 9'h000, 1'b0);
    single("zero",   32'h0000_0000, 3'b000, 2'b00, 2'b00, 4'b0000, 9'h000, 1'b1);
`ifdef DECODE_MEXT_EN
    single("mul",    32'h0200_00B3, 3'b000, 2'b00, 2'b00, 4'b0000, 9'h000, 1'b0);
`else
    single("mul",    32'h0200_00B3, 3'b000, 2'b00, 2'b00, 4'b0000, 9'h000, 1'b1);
`endif
    single("sw",     32'h0020_A223, 3'b001, 2'b00, 2'b01, 4'b0000, 9'h060, 1'b0);
    single("sw_f3",  32'h0020_B223, 3'b000, 2'b00, 2'b00, 4'b0000, 9'h000, 1'b1);
    single("sub",    32'h4031_00B3, 3'b000, 2'b00, 2'b00, 4'b1000, 9'h000, 1'b0);
    single("alt_f3", 32'h4031_10B3, 3'b000, 2'b00, 2'b00, 4'b0000, 9'h000, 1'b1);
    single("lui",    32'h1234_50B7, 3'b011, 2'b01, 2'b11, 4'b0000, 9'h001, 1'b0);

    // MUL muldiv flag checked on its own vector.
    drive(1'b1, 32'h0200_00B3, 32'h0000_0500, 1'b1);
    tick();
`ifdef DECODE_MEXT_EN
    check("mul.muldiv", 64'(bus.id_muldiv_o), 64'd1);
`else
    check("mul.muldiv", 64'(bus.id_muldiv_o), 64'd0);
    exp_cnt++;
`endif
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    tick();

    // Flush with both entries full; flushed illegal words must never reach the counter.
    drive(1'b1, 32'h0000_0000, 32'h0000_0600, 1'b0);
    tick();
    drive(1'b1, 32'h0000_0000, 32'h0000_0604, 1'b0);
    tick();
    check("fl.full", 64'(bus.if_ready_o), 64'd0);
    drive(1'b1, 32'h0000_0000, 32'h0000_0608, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    check("fl.valid",    64'(bus.id_valid_o), 64'd0);
    check("fl.if_ready", 64'(bus.if_ready_o), 64'd1);
    tick();
    tick();
    check("fl.stay_empty", 64'(bus.id_valid_o),    64'd0);
    check("fl.cnt",        64'(bus.illegal_cnt_o), 64'(exp_cnt));

    // Flush discards a same-cycle accept.
    drive(1'b1, 32'h0010_0113, 32'h0000_0700, 1'b0);
    tick();
    drive(1'b1, 32'h0000_0000, 32'h0000_0704, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    check("fl2.valid", 64'(bus.id_valid_o), 64'd0);
    tick();
    check("fl2.no_leak", 64'(bus.id_valid_o),    64'd0);
    check("fl2.cnt",     64'(bus.illegal_cnt_o), 64'(exp_cnt));

    // Saturation on the 2-bit counter instance: five illegal handoffs.
    bus2.if_valid_i = 1'b1;
    tick();
    tick();
    tick();
    check("sat.two", 64'(bus2.illegal_cnt_o), 64'd2);
    tick();
    check("sat.three", 64'(bus2.illegal_cnt_o), 64'd3);
    tick();
    bus2.if_valid_i = 1'b0;
    tick();
    check("sat.hold", 64'(bus2.illegal_cnt_o), 64'd3);
    check("sat.empty_after", 64'(bus2.id_valid_o), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
